// File: rtl/himax_px_tx_pkg.sv
// Shared types for the Himax-style pixel transmitter.
// State and pattern encodings plus a counter width helper.
package himax_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FGAP,
      S_FPRE,
      S_LINE,
      S_HBLANK,
      S_FPOST
   } state_t;

   typedef enum logic [1:0] {
      PAT_STREAM,
      PAT_COL,
      PAT_ROW,
      PAT_FCNT
   } pat_t;

   function automatic int cw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/himax_px_tx_if.sv
// Upstream pixel stream: 8-bit data with valid/ready handshake.
// The transmitter is the slave side.
interface himax_px_tx_if;

   logic [7:0] data;
   logic       valid;
   logic       ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/himax_px_tx.sv
// Himax-style parallel pixel transmitter: fv/lv framing and a 4-bit
// nibble bus, high nibble first, fed by a stream or a test pattern.
module himax_px_tx
   import himax_tx_pkg::*;
#(
   parameter int H_ACTIVE = 324,
   parameter int V_ACTIVE = 244,
   parameter int H_BLANK  = 16,
   parameter int V_BLANK  = 64
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enable,
   input  logic [1:0]       pattern,
   himax_px_tx_if.slave     s,
   output logic             px_fv,
   output logic             px_lv,
   output logic [3:0]       pxd,
   output logic             frame_start,
   output logic             frame_done,
   output logic             underrun,
   output logic [7:0]       frame_cnt
);

   localparam int LCYC = 2 * H_ACTIVE;
   localparam int M1   = (LCYC > H_BLANK) ? LCYC : H_BLANK;
   localparam int CMAX = (M1 > V_BLANK) ? M1 : V_BLANK;
   localparam int CW   = cw(CMAX);
   localparam int RW   = cw(V_ACTIVE);
   localparam int XW   = cw(H_ACTIVE);

   localparam logic [CW-1:0] L_END = CW'(LCYC - 1);
   localparam logic [CW-1:0] B_END = CW'(H_BLANK - 1);
   localparam logic [CW-1:0] G_END = CW'(V_BLANK - 1);
   localparam logic [RW-1:0] R_END = RW'(V_ACTIVE - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [RW-1:0] row;
   logic [XW-1:0] col;
   pat_t          pat_q;
   logic [3:0]    lo_q;
   logic          cnt_end;
   logic          fetch;
   logic          fv_nxt;
   logic          lv_nxt;
   logic [7:0]    pix;
   logic [3:0]    pxd_nxt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The last line skips S_HBLANK so one blank separates it from fv fall.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      cnt_end   = 1'b0;
      unique case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (enable) state_nxt = S_FGAP;
         end
         S_FGAP: begin
            cnt_end = (cnt == G_END);
            if (cnt_end) state_nxt = S_FPRE;
         end
         S_FPRE: begin
            cnt_end = (cnt == B_END);
            if (cnt_end) state_nxt = S_LINE;
         end
         S_LINE: begin
            cnt_end = (cnt == L_END);
            if (cnt_end) state_nxt = (row == R_END) ? S_FPOST : S_HBLANK;
         end
         S_HBLANK: begin
            cnt_end = (cnt == B_END);
            if (cnt_end) state_nxt = S_LINE;
         end
         S_FPOST: begin
            cnt_end = (cnt == B_END);
            if (cnt_end) state_nxt = enable ? S_FGAP : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (cnt_end) cnt_nxt = '0;
   end

   assign fetch    = (state == S_LINE) && !cnt[0];
   assign s.ready  = fetch && (pat_q == PAT_STREAM);
   assign underrun = s.ready && !s.valid;
   assign fv_nxt   = state inside {S_FPRE, S_LINE, S_HBLANK, S_FPOST};
   assign lv_nxt   = (state == S_LINE);

   always_comb begin
      pix = '0;
      unique case (pat_q)
         PAT_STREAM: pix = s.valid ? s.data : 8'h00;
         PAT_COL:    pix = 8'(col);
         PAT_ROW:    pix = 8'(row);
         PAT_FCNT:   pix = frame_cnt;
         default:    pix = '0;
      endcase
   end

   always_comb begin
      pxd_nxt = '0;
      if (lv_nxt) pxd_nxt = fetch ? pix[7:4] : lo_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         px_fv       <= 1'b0;
         px_lv       <= 1'b0;
         pxd         <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         frame_cnt   <= '0;
         pat_q       <= PAT_STREAM;
         lo_q        <= '0;
         row         <= '0;
         col         <= '0;
      end else begin
         px_fv       <= fv_nxt;
         px_lv       <= lv_nxt;
         pxd         <= pxd_nxt;
         frame_start <= fv_nxt && !px_fv;
         frame_done  <= !fv_nxt && px_fv;
         if (px_fv && !fv_nxt) frame_cnt <= frame_cnt + 8'd1;
         if (fetch) lo_q <= pix[3:0];
         if (state == S_FGAP && cnt_end) begin
            pat_q <= pat_t'(pattern);
            row   <= '0;
         end
         if (state == S_LINE) begin
            if (cnt[0]) col <= col + 1'b1;
            if (cnt_end) begin
               col <= '0;
               row <= row + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_himax_px_tx.sv
// Scoreboard bench for himax_px_tx with a small frame geometry.
// Expected pixels and per-line handshake counts are queued by stimulus.
module tb_himax_px_tx;

   localparam int HA = 4;
   localparam int VA = 2;
   localparam int HB = 2;
   localparam int VB = 3;
   localparam int FV_LEN = 2 * HB + VA * 2 * HA + (VA - 1) * HB;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       enable = 1'b0;
   logic [1:0] pattern = 2'd0;
   logic       px_fv, px_lv, frame_start, frame_done, underrun;
   logic [3:0] pxd;
   logic [7:0] frame_cnt;

   himax_px_tx_if sif ();

   himax_px_tx #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB)
   ) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .pattern(pattern),
      .s(sif), .px_fv(px_fv), .px_lv(px_lv), .pxd(pxd),
      .frame_start(frame_start), .frame_done(frame_done),
      .underrun(underrun), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q[$];
   int         hs_q[$];
   logic [8:0] slot_q[$];
   int hs_line = 0, urun_cnt = 0, fs_cnt = 0, fd_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Stream source: one slot is consumed per fetch, valid or not.
   bit drv_fetch;
   initial begin
      sif.data  = 8'h00;
      sif.valid = 1'b0;
      forever begin
         @(negedge clk);
         drv_fetch = resetn && sif.ready;
         @(posedge clk);
         #1;
         if (drv_fetch && slot_q.size() > 0) void'(slot_q.pop_front());
         if (slot_q.size() > 0) {sif.valid, sif.data} = slot_q[0];
         else {sif.valid, sif.data} = 9'h0;
      end
   end

   // Monitor: framing checks and pixel scoreboard.
   bit prev_fv, prev_lv, gap_chk, half, bad_idle;
   int fv_len, lv_len, gap_len, lines;
   logic [3:0] hi;
   always @(negedge clk) begin
      if (!resetn) begin
         prev_fv = 0; prev_lv = 0; gap_chk = 0; half = 0; bad_idle = 0;
         fv_len = 0; lv_len = 0; gap_len = 0; lines = 0; hs_line = 0;
      end else begin
         if (sif.ready && sif.valid) hs_line++;
         if (underrun) urun_cnt++;
         if (frame_start) fs_cnt++;
         if (frame_done) fd_cnt++;
         if (px_fv && !prev_fv) begin
            chk("frame_start", frame_start, 1);
            if (gap_chk) chk("fv_gap", gap_len, VB);
            gap_chk = 0; fv_len = 0; lines = 0; half = 0; bad_idle = 0;
            hs_line = 0;
         end
         if (!px_fv && prev_fv) begin
            chk("frame_done", frame_done, 1);
            chk("fv_len", fv_len, FV_LEN);
            chk("lines", lines, VA);
            chk("pxd_idle_zero", bad_idle, 0);
            gap_chk = enable;
            gap_len = 0;
         end
         if (px_fv) fv_len++;
         else gap_len++;
         if (px_lv) begin
            lv_len++;
            if (!half) begin
               hi = pxd;
               half = 1;
            end else begin
               half = 0;
               if (exp_q.size() == 0) chk("sb_empty", {hi, pxd}, 32'hFFFF);
               else chk("pixel", {hi, pxd}, exp_q.pop_front());
            end
         end else begin
            if (pxd != 4'h0) bad_idle = 1;
            if (prev_lv) begin
               chk("lv_len", lv_len, 2 * HA);
               lines++;
               if (hs_q.size() > 0) chk("hs_per_line", hs_line, hs_q.pop_front());
               lv_len = 0;
               hs_line = 0;
            end
         end
         prev_fv = px_fv;
         prev_lv = px_lv;
      end
   end

   task automatic wait_pulse(input bit done, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(done ? frame_done : frame_start) && n < budget);
      if (!(done ? frame_done : frame_start))
         chk(done ? "wait_done" : "wait_start", 0, 1);
   endtask

   task automatic push_frame(input int mode, input int base);
      for (int l = 0; l < VA; l++)
         for (int c = 0; c < HA; c++)
            exp_q.push_back(mode == 1 ? 8'(c) : mode == 2 ? 8'(l) : 8'(base));
   endtask

   task automatic one_frame();
      enable = 1'b1;
      wait_pulse(0, 100);
      enable = 1'b0;
      wait_pulse(1, 100);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int u0, n;
      logic [7:0] sdat[16];
      logic [7:0] udat[8];
      sdat = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E,
               8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hEF};
      udat = '{8'h11, 8'hEE, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

      repeat (3) @(negedge clk);
      chk("rst_fv", px_fv, 0);
      chk("rst_lv", px_lv, 0);
      chk("rst_pxd", pxd, 0);
      chk("rst_fcnt", frame_cnt, 0);
      chk("rst_ready", sif.ready, 0);
      chk("rst_underrun", underrun, 0);
      resetn = 1'b1;
      @(negedge clk);

      pattern = 2'd1;
      push_frame(1, 0);
      hs_q = '{0, 0};
      one_frame();
      repeat (10) @(negedge clk);
      chk("idle_fv", px_fv, 0);
      chk("fs_cnt", fs_cnt, 1);
      chk("fd_cnt", fd_cnt, 1);
      chk("fcnt_1", frame_cnt, 1);

      pattern = 2'd2;
      push_frame(2, 0);
      hs_q = '{0, 0};
      one_frame();
      chk("fcnt_2", frame_cnt, 2);

      pattern = 2'd0;
      u0 = urun_cnt;
      for (int i = 0; i < 16; i++) begin
         slot_q.push_back({1'b1, sdat[i]});
         exp_q.push_back(sdat[i]);
      end
      hs_q = '{4, 4, 4, 4};
      enable = 1'b1;
      wait_pulse(0, 100);
      wait_pulse(0, 100);
      enable = 1'b0;
      wait_pulse(1, 100);
      repeat (4) @(negedge clk);
      chk("stream_underrun", urun_cnt - u0, 0);
      chk("stream_slots", slot_q.size(), 0);
      chk("fcnt_4", frame_cnt, 4);

      u0 = urun_cnt;
      for (int i = 0; i < 8; i++) begin
         slot_q.push_back({i != 1, udat[i]});
         exp_q.push_back(i == 1 ? 8'h00 : udat[i]);
      end
      hs_q = '{3, 4};
      one_frame();
      chk("underrun_pulses", urun_cnt - u0, 1);
      chk("fcnt_5", frame_cnt, 5);

      pattern = 2'd3;
      for (int f = 0; f < 256; f++) push_frame(3, (5 + f) & 255);
      enable = 1'b1;
      for (int f = 0; f < 256; f++) wait_pulse(0, 100);
      enable = 1'b0;
      wait_pulse(1, 100);
      repeat (4) @(negedge clk);
      chk("wrap_fcnt", frame_cnt, 5);
      chk("wrap_sb_drained", exp_q.size(), 0);

      pattern = 2'd1;
      push_frame(1, 0);
      enable = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!px_lv && n < 100);
      chk("wait_lv", px_lv, 1);
      resetn = 1'b0;
      #1;
      chk("arst_fv", px_fv, 0);
      chk("arst_lv", px_lv, 0);
      chk("arst_pxd", pxd, 0);
      chk("arst_ready", sif.ready, 0);
      chk("arst_fcnt", frame_cnt, 0);
      exp_q.delete();
      hs_q.delete();
      slot_q.delete();
      repeat (2) @(negedge clk);
      push_frame(1, 0);
      resetn = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!px_fv && n < 50);
      chk("rst_first_gap", n, 5);
      enable = 1'b0;
      wait_pulse(1, 100);
      repeat (4) @(negedge clk);
      chk("post_rst_fcnt", frame_cnt, 1);
      chk("sb_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
